cache_mem_arbiter: RTL and testbench

Two-port line arbiter that shares the single physical-memory port between the instruction cache and the data cache of the pipelined RV32I core. It accepts one outstanding cache-line transaction at a time, selects a requester with round-robin priority when both are pending, and latches the winner's request. It then drives the downstream line port until `mem_resp` and routes the response back to the winner only.

---
 rtl/cache_mem_arbiter_if.sv | 40 ++++
 rtl/cache_mem_arbiter.sv | 105 ++++++++++
 tb/tb_cache_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the icache, dcache and downstream line-port signals shared by the
// cache/memory arbiter. The arbiter takes the slave view; the caches plus
// the memory (or a test environment standing in for them) take the master view.
interface cache_mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the icache
// and dcache. One transaction in flight; the winner's request is latched at
// grant so the downstream port sees stable address/data for the whole access.
// A one-cycle RECOVER state after each response lets the requester drop its
// request before arbitration resumes, so a stale request is never re-granted.
module cache_mem_arbiter #(
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input logic               clk,
  input logic               rst,
  cache_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE, RECOVER} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

  state_t            state, next_state;
  owner_t            owner, last_owner, grant_owner;
  logic              op_write;
  logic              grant;
  logic              i_req, d_req;
  logic              serving, done;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;

  assign i_req   = bus.i_read;
  assign d_req   = bus.d_read | bus.d_write;
  assign serving = (state == SERVE);
  assign done    = serving & bus.mem_resp;

  // Next-state and grant decision; on a tie the port that did not win last time goes.
  always_comb begin
    next_state  = state;
    grant       = 1'b0;
    grant_owner = OWN_I;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant       = 1'b1;
          grant_owner = (d_req && (!i_req || last_owner == OWN_I)) ? OWN_D : OWN_I;
          next_state  = SERVE;
        end
      end
      SERVE:   if (bus.mem_resp) next_state = RECOVER;
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Ownership and operation type, captured at grant; fairness history at completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_I;
      last_owner <= OWN_I;
      op_write   <= 1'b0;
    end else begin
      if (grant) begin
        owner    <= grant_owner;
        op_write <= (grant_owner == OWN_D) & bus.d_write;
      end
      if (done) last_owner <= owner;
    end
  end

  // Latched line address and writeback data; outputs are gated outside SERVE.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_q <= ((grant_owner == OWN_D) ? bus.d_address : bus.i_address) & LINE_MASK;
      if (grant_owner == OWN_D && bus.d_write) wdata_q <= bus.d_wdata;
    end
  end

  // Last line delivered to each port, held between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (done) begin
      if (owner == OWN_I) i_rdata_q <= bus.mem_rdata;
      else                d_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_read    = serving & ~op_write;
  assign bus.mem_write   = serving & op_write;
  assign bus.mem_address = serving ? addr_q  : '0;
  assign bus.mem_wdata   = serving ? wdata_q : '0;

  assign bus.i_resp  = done & (owner == OWN_I);
  assign bus.d_resp  = done & (owner == OWN_D);
  assign bus.i_rdata = bus.i_resp ? bus.mem_rdata : i_rdata_q;
  assign bus.d_rdata = bus.d_resp ? bus.mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed transactions, a latency-programmable
// memory responder, and a scoreboard monitor checking every downstream request
// and every cache response against queued expectations.
module tb_cache_mem_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [LINE_W-1:0] JUNK = {32{8'hEE}};

  typedef struct { logic port; logic [LINE_W-1:0] data; int lat; } resp_t;
  typedef struct { logic wr; logic [ADDR_W-1:0] addr; logic [LINE_W-1:0] wdata; } op_t;
  typedef struct { int lat; logic [LINE_W-1:0] data; } mem_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic auto_resp = 1'b0;
  logic force_resp = 1'b0;
  logic mon_en = 1'b0;
  logic chk_gap = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   resp_count = 0;

  resp_t exp_resp_q[$];
  op_t   exp_op_q[$];
  mem_t  mem_q[$];

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFFSET_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_resp = auto_resp | force_resp;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input logic port, input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [LINE_W-1:0] wdata, input int lat,
                            input logic [LINE_W-1:0] rdata);
    resp_t r;
    op_t   o;
    mem_t  m;
    o.wr = wr; o.addr = addr; o.wdata = wdata;
    exp_op_q.push_back(o);
    r.port = port; r.data = rdata; r.lat = lat;
    exp_resp_q.push_back(r);
    m.lat = lat; m.data = rdata;
    mem_q.push_back(m);
  endtask

  task automatic wait_mem_req(input int budget);
    int n = 0;
    while (!(bus.mem_read || bus.mem_write) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("wait_mem_req_timeout", bus.mem_read | bus.mem_write, 1);
  endtask

  task automatic wait_resp(input int target, input int budget);
    int n = 0;
    while (resp_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (resp_count < target) chk("wait_resp_timeout", resp_count, target);
  endtask

  // Memory model: answers each request after the queued number of SERVE cycles.
  initial begin
    logic r_active;
    int   r_cnt;
    mem_t r_cur;
    r_active = 1'b0;
    r_cnt = 0;
    r_cur.lat = 1;
    r_cur.data = '0;
    bus.mem_rdata = JUNK;
    forever begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) begin
        if (!r_active) begin
          r_active = 1'b1;
          r_cnt = 0;
          if (mem_q.size() > 0) r_cur = mem_q.pop_front();
          else begin r_cur.lat = 1; r_cur.data = '0; end
        end
        r_cnt++;
        if (r_cnt == r_cur.lat) begin
          auto_resp = 1'b1;
          bus.mem_rdata = r_cur.data;
          r_active = 1'b0;
        end else begin
          auto_resp = 1'b0;
          bus.mem_rdata = JUNK;
        end
      end else begin
        auto_resp = 1'b0;
        r_active = 1'b0;
        bus.mem_rdata = JUNK;
      end
    end
  end

  // Scoreboard monitor: samples after the responder has settled each cycle.
  initial begin
    logic  in_txn;
    logic  req;
    int    serve_cnt;
    int    cyc;
    int    last_resp_cyc;
    op_t   cur_op;
    resp_t r;
    in_txn = 1'b0;
    serve_cnt = 0;
    cyc = 0;
    last_resp_cyc = 0;
    cur_op.wr = 1'b0; cur_op.addr = '0; cur_op.wdata = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      req = bus.mem_read | bus.mem_write;
      if (!mon_en) begin
        in_txn = 1'b0;
      end else begin
        if (req && !in_txn) begin
          in_txn = 1'b1;
          serve_cnt = 0;
          if (chk_gap) chk("resp_to_next_req_gap", cyc - last_resp_cyc, 3);
          if (exp_op_q.size() == 0) begin
            chk("unexpected_mem_req", req, 0);
          end else begin
            cur_op = exp_op_q.pop_front();
            chk("mem_write", bus.mem_write, cur_op.wr);
            chk("mem_read", bus.mem_read, !cur_op.wr);
            chk("mem_address", bus.mem_address, cur_op.addr);
            if (cur_op.wr) chk("mem_wdata", bus.mem_wdata, cur_op.wdata);
          end
        end
        if (in_txn) serve_cnt++;
        if (bus.i_resp || bus.d_resp) begin
          chk("resp_exclusive", bus.i_resp & bus.d_resp, 0);
          chk("resp_during_serve", bus.mem_resp & in_txn, 1);
          if (exp_resp_q.size() == 0) begin
            chk("unexpected_resp", bus.i_resp | bus.d_resp, 0);
          end else begin
            r = exp_resp_q.pop_front();
            chk("resp_port_is_d", bus.d_resp, r.port);
            chk("resp_data", r.port ? bus.d_rdata : bus.i_rdata, r.data);
            chk("serve_cycles", serve_cnt, r.lat);
            chk("mem_address_at_resp", bus.mem_address, cur_op.addr);
            if (cur_op.wr) chk("mem_wdata_at_resp", bus.mem_wdata, cur_op.wdata);
          end
          in_txn = 1'b0;
          last_resp_cyc = cyc;
          resp_count++;
        end else if (in_txn && !req) begin
          chk("req_dropped_without_resp", req, 1);
          in_txn = 1'b0;
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;

    // Outputs while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_i_resp", bus.i_resp, 0);
    chk("rst_d_resp", bus.d_resp, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    rst = 1'b1;

    // Reset asserted in the middle of a long read.
    mem_q.push_back('{lat: 100, data: '0});
    bus.i_address = 32'h0000_1234;
    bus.i_read = 1'b1;
    @(negedge clk);
    wait_mem_req(20);
    @(negedge clk);
    chk("pre_reset_mem_read", bus.mem_read, 1);
    chk("pre_reset_mem_address", bus.mem_address, 32'h0000_1220);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_mem_read", bus.mem_read, 0);
    chk("async_rst_mem_write", bus.mem_write, 0);
    chk("async_rst_mem_address", bus.mem_address, 0);
    chk("async_rst_i_resp", bus.i_resp, 0);
    bus.i_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_q.delete();
    @(negedge clk);
    mon_en = 1'b1;

    // Both requesting continuously: D wins the first tie, then strict alternation.
    expect_txn(1'b1, 1'b0, 32'h0000_2040, '0, 2, {8{32'hD000_0001}});
    expect_txn(1'b0, 1'b0, 32'h0000_1220, '0, 1, {8{32'h1000_0001}});
    expect_txn(1'b1, 1'b0, 32'h0000_2040, '0, 2, {8{32'hD000_0002}});
    expect_txn(1'b0, 1'b0, 32'h0000_1220, '0, 1, {8{32'h1000_0002}});
    bus.i_address = 32'h0000_1234;
    bus.d_address = 32'h0000_2048;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    wait_resp(1, 50);
    chk_gap = 1'b1;
    wait_resp(4, 100);
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    chk_gap = 1'b0;
    repeat (3) @(negedge clk);

    // Single icache read with three-cycle memory.
    expect_txn(1'b0, 1'b0, 32'h0000_1220, '0, 3, {32{8'hA5}});
    bus.i_address = 32'h0000_1234;
    bus.i_read = 1'b1;
    wait_resp(5, 50);
    bus.i_read = 1'b0;
    repeat (3) @(negedge clk);

    // dcache writeback; live write data changes mid-transaction.
    expect_txn(1'b1, 1'b1, 32'h8000_0040, {8{32'h1122_3344}}, 3, {8{32'h0BAD_F00D}});
    bus.d_address = 32'h8000_0040;
    bus.d_wdata = {8{32'h1122_3344}};
    bus.d_write = 1'b1;
    @(negedge clk);
    wait_mem_req(20);
    bus.d_wdata = {8{32'hDEAD_BEEF}};
    wait_resp(6, 50);
    bus.d_write = 1'b0;
    repeat (3) @(negedge clk);

    // Stray mem_resp while idle: no pulse, no grant, held line data unchanged.
    force_resp = 1'b1;
    #2;
    chk("idle_mem_resp_i_resp", bus.i_resp, 0);
    chk("idle_mem_resp_d_resp", bus.d_resp, 0);
    @(negedge clk);
    force_resp = 1'b0;
    #2;
    chk("idle_after_stray_mem_read", bus.mem_read, 0);
    chk("idle_after_stray_mem_write", bus.mem_write, 0);
    chk("held_i_rdata", bus.i_rdata, {32{8'hA5}});
    chk("held_d_rdata", bus.d_rdata, {8{32'h0BAD_F00D}});
    repeat (2) @(negedge clk);

    // Read and write together behave as a write; zero-wait memory.
    expect_txn(1'b1, 1'b1, 32'h0000_3000, {8{32'h5555_AAAA}}, 1, {8{32'h7777_0000}});
    bus.d_address = 32'h0000_3010;
    bus.d_wdata = {8{32'h5555_AAAA}};
    bus.d_read = 1'b1;
    bus.d_write = 1'b1;
    wait_resp(7, 50);
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    repeat (4) @(negedge clk);

    chk("pending_resp_expectations", exp_resp_q.size(), 0);
    chk("pending_op_expectations", exp_op_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
